// File: rtl/obstacle_nav_ctrl_pkg.sv
// rtl/obstacle_nav_ctrl_pkg.sv - shared motor codes, state codes and helpers for obstacle_nav_ctrl
// Contents: nav_state_e (state_dbg encoding), ST_* motor command codes, spin_code(), max3().
package obstacle_nav_ctrl_pkg;

  // Values are exported on state_dbg, so they are fixed.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_BRAKE = 3'd2,
    S_TURN  = 3'd3,
    S_CHECK = 3'd4
  } nav_state_e;

  // Motor command codes decoded by the H-bridge stage into aa/ab/ba/bb.
  localparam logic [1:0] ST_STOP   = 2'b00;
  localparam logic [1:0] ST_FWD    = 2'b11;
  localparam logic [1:0] ST_SPIN_R = 2'b01;
  localparam logic [1:0] ST_SPIN_L = 2'b10;

  // turn_dir: 0 = right, 1 = left.
  function automatic logic [1:0] spin_code(input logic dir_left);
    return dir_left ? ST_SPIN_L : ST_SPIN_R;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/obstacle_nav_ctrl_if.sv
// rtl/obstacle_nav_ctrl_if.sv - sample input and motor command bundle for obstacle_nav_ctrl
// Signals: enable (run request), dist_cm[8:0] / dist_valid (ranging sample strobe),
// status[1:0] (motor command), state_dbg[2:0] (current state).
// master: ranging/host side that drives samples; slave: the navigation controller.
interface obstacle_nav_ctrl_if;
  logic       enable;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic [1:0] status;
  logic [2:0] state_dbg;

  modport master (
    output enable,
    output dist_cm,
    output dist_valid,
    input  status,
    input  state_dbg
  );

  modport slave (
    input  enable,
    input  dist_cm,
    input  dist_valid,
    output status,
    output state_dbg
  );
endinterface

// File: rtl/obstacle_nav_ctrl_ms_tick.sv
// rtl/obstacle_nav_ctrl_ms_tick.sv - free-running 1 ms tick prescaler
// Ports: clk, rst (sync, active-high), tick (1-cycle pulse every CLK_HZ/1000 clocks).
module obstacle_nav_ctrl_ms_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/obstacle_nav_ctrl.sv
// rtl/obstacle_nav_ctrl.sv - forward / brake / spin / check navigation FSM
// Ports: clk, rst (sync, active-high), nav (obstacle_nav_ctrl_if.slave):
//   enable, dist_cm[8:0], dist_valid in; status[1:0], state_dbg[2:0] out (registered).
module obstacle_nav_ctrl
  import obstacle_nav_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STOP_CM    = 20,
  parameter int CLEAR_CM   = 30,
  parameter int CONFIRM_N  = 2,
  parameter int BRAKE_MS   = 200,
  parameter int TURN_MS    = 400,
  parameter int WDOG_MS    = 100,
  parameter int TURN_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  obstacle_nav_ctrl_if.slave   nav
);

  localparam int MS_MAX = max3(BRAKE_MS, TURN_MS, WDOG_MS);
  localparam int MSW    = $clog2(MS_MAX + 1);
  localparam int FW     = (TURN_LIMIT > 0) ? $clog2(TURN_LIMIT + 1) : 1;

  logic tick;

  obstacle_nav_ctrl_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  nav_state_e     state;
  logic [1:0]     status_q;
  logic [2:0]     dbg_q;
  logic [MSW-1:0] ms_cnt;    // dwell in BRAKE/TURN, watchdog in FWD/CHECK
  logic [3:0]     near_cnt;
  logic [FW-1:0]  fail_cnt;
  logic           turn_dir;  // 0 = right, 1 = left

  assign nav.status    = status_q;
  assign nav.state_dbg = dbg_q;

  // dist_cm == 0 means no echo; such strobes are dropped entirely.
  logic accepted, is_near, is_clear;
  assign accepted = nav.dist_valid && (nav.dist_cm != 9'd0);
  assign is_near  = nav.dist_cm <  9'(STOP_CM);
  assign is_clear = nav.dist_cm >= 9'(CLEAR_CM);

  logic wdog_exp, brake_done, turn_done;
  assign wdog_exp   = tick && (ms_cnt == MSW'(WDOG_MS - 1));
  assign brake_done = tick && (ms_cnt == MSW'(BRAKE_MS - 1));
  assign turn_done  = tick && (ms_cnt == MSW'(TURN_MS - 1));

  logic [MSW-1:0] ms_inc;
  logic [3:0]     near_inc;
  logic [FW-1:0]  fail_inc;
  assign ms_inc   = (ms_cnt == '1) ? ms_cnt : ms_cnt + 1'b1;
  assign near_inc = (near_cnt == 4'hF) ? near_cnt : near_cnt + 4'd1;
  assign fail_inc = (fail_cnt >= FW'(TURN_LIMIT)) ? fail_cnt : fail_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      status_q <= ST_STOP;
      dbg_q    <= S_IDLE;
      ms_cnt   <= '0;
      near_cnt <= '0;
      fail_cnt <= '0;
      turn_dir <= 1'b0;
    end else if (!nav.enable) begin
      state    <= S_IDLE;
      status_q <= ST_STOP;
      dbg_q    <= S_IDLE;
      ms_cnt   <= '0;
      near_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_CHECK;
          status_q <= ST_STOP;
          dbg_q    <= S_CHECK;
          ms_cnt   <= '0;
        end

        S_FWD: begin
          if (wdog_exp) begin
            state    <= S_BRAKE;
            status_q <= ST_STOP;
            dbg_q    <= S_BRAKE;
            ms_cnt   <= '0;
            near_cnt <= '0;
          end else if (accepted) begin
            ms_cnt <= '0;
            if (!is_near) begin
              near_cnt <= '0;  // includes the hysteresis band
            end else if (near_inc >= 4'(CONFIRM_N)) begin
              state    <= S_BRAKE;
              status_q <= ST_STOP;
              dbg_q    <= S_BRAKE;
              near_cnt <= '0;
            end else begin
              near_cnt <= near_inc;
            end
          end else if (tick) begin
            ms_cnt <= ms_inc;
          end
        end

        S_BRAKE: begin
          if (brake_done) begin
            state    <= S_TURN;
            status_q <= spin_code(turn_dir);
            dbg_q    <= S_TURN;
            ms_cnt   <= '0;
          end else if (tick) begin
            ms_cnt <= ms_inc;
          end
        end

        S_TURN: begin
          if (turn_done) begin
            state    <= S_CHECK;
            status_q <= ST_STOP;
            dbg_q    <= S_CHECK;
            ms_cnt   <= '0;
            // The turn that hit the limit runs in the old direction; the flip
            // applies from the next turn so status always tracks turn_dir.
            if (fail_cnt >= FW'(TURN_LIMIT)) begin
              turn_dir <= ~turn_dir;
              fail_cnt <= '0;
            end
          end else if (tick) begin
            ms_cnt <= ms_inc;
          end
        end

        S_CHECK: begin
          if (wdog_exp) begin
            state    <= S_IDLE;
            status_q <= ST_STOP;
            dbg_q    <= S_IDLE;
            ms_cnt   <= '0;
          end else if (accepted) begin
            ms_cnt <= '0;
            if (is_clear) begin
              state    <= S_FWD;
              status_q <= ST_FWD;
              dbg_q    <= S_FWD;
              near_cnt <= '0;
              fail_cnt <= '0;
            end else begin
              state    <= S_TURN;
              status_q <= spin_code(turn_dir);
              dbg_q    <= S_TURN;
              fail_cnt <= fail_inc;
            end
          end else if (tick) begin
            ms_cnt <= ms_inc;
          end
        end

        default: begin
          state    <= S_IDLE;
          status_q <= ST_STOP;
          dbg_q    <= S_IDLE;
          ms_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
